// File: rtl/axi_modport_slave_if.sv
// AXI3-style bus bundle between a master and a memory-backed slave.
// The monitor view observes every signal without driving anything.
interface axi_modport_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [3:0]            AWID;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [3:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [3:0]            WID;
  logic [DATA_WIDTH-1:0] WDATA;
  logic [3:0]            WSTRB;
  logic                  WLAST;
  logic                  WVALID;
  logic                  WREADY;
  logic [3:0]            BID;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic [3:0]            ARID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [3:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [3:0]            RID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
    output WID, WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input  BID, BRESP, BVALID, output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
    input  WID, WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BID, BRESP, BVALID, input BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
  );

  modport monitor (
    input AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, AWREADY,
    input WID, WDATA, WSTRB, WLAST, WVALID, WREADY,
    input BID, BRESP, BVALID, BREADY,
    input ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, ARREADY,
    input RID, RDATA, RRESP, RLAST, RVALID, RREADY
  );
endinterface

// File: rtl/axi_modport_slave.sv
// Memory-backed AXI3-style slave: independent write and read FSMs over a
// word-addressed RAM, one outstanding transaction per channel.
module axi_modport_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input logic                clk,
  input logic                rst,
  axi_modport_slave_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned NBYTE = DATA_WIDTH / 8;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // Address of the beat after a, for the given size/burst/len.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
      input logic [2:0] size, input logic [1:0] burst, input logic [3:0] len);
    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] wmask;
    bytes = ADDR_WIDTH'(1) << size;
    wmask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * bytes) - ADDR_WIDTH'(1);
    case (burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (a & ~wmask) | ((a + bytes) & wmask);
      default: next_addr = (a & ~(bytes - ADDR_WIDTH'(1))) + bytes;
    endcase
  endfunction

  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
      input logic [3:0] len);
    burst_err = (size > 3'd2) || (burst == 2'b11) ||
                ((burst == 2'b10) && !((len == 4'd1) || (len == 4'd3) ||
                                       (len == 4'd7) || (len == 4'd15)));
  endfunction

  function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] a);
    addr_oor = a[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(MEM_DEPTH);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  w_state_e              w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [3:0]            aw_len_q, aw_len_d, w_beat_q, w_beat_d;
  logic [2:0]            aw_size_q, aw_size_d;
  logic [1:0]            aw_burst_q, aw_burst_d;
  logic                  w_err_q, w_err_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [3:0]            bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;

  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [3:0]            ar_len_q, ar_len_d, r_beat_q, r_beat_d;
  logic [2:0]            ar_size_q, ar_size_d;
  logic [1:0]            ar_burst_q, ar_burst_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [3:0]            rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic                  mem_we, w_beat_err, r_load, r_load_berr, r_load_err;
  logic [IDX_W-1:0]      mem_widx;
  logic [ADDR_WIDTH-1:0] r_load_addr;
  logic                  unused_wid;

  assign unused_wid  = ^bus.WID;
  assign w_beat_err  = addr_oor(aw_addr_q) || (bus.WLAST != (w_beat_q == aw_len_q));
  assign bus.AWREADY = awready_q;
  assign bus.WREADY  = wready_q;
  assign bus.BVALID  = bvalid_q;
  assign bus.BID     = bid_q;
  assign bus.BRESP   = bresp_q;
  assign bus.ARREADY = arready_q;
  assign bus.RVALID  = rvalid_q;
  assign bus.RID     = rid_q;
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = rresp_q;
  assign bus.RLAST   = rlast_q;

  // Write channel next state: address, data beats, response.
  always_comb begin
    w_state_d  = w_state_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    w_beat_d   = w_beat_q;
    w_err_d    = w_err_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    mem_we     = 1'b0;
    mem_widx   = aw_addr_q[IDX_W+1:2];
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (bus.AWVALID && awready_q) begin
          aw_addr_d  = bus.AWADDR;
          aw_len_d   = bus.AWLEN;
          aw_size_d  = bus.AWSIZE;
          aw_burst_d = bus.AWBURST;
          bid_d      = bus.AWID;
          w_beat_d   = 4'd0;
          w_err_d    = burst_err(bus.AWSIZE, bus.AWBURST, bus.AWLEN);
          awready_d  = 1'b0;
          wready_d   = 1'b1;
          w_state_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (bus.WVALID && wready_q) begin
          mem_we    = !addr_oor(aw_addr_q);
          w_err_d   = w_err_q || w_beat_err;
          aw_addr_d = next_addr(aw_addr_q, aw_size_q, aw_burst_q, aw_len_q);
          w_beat_d  = w_beat_q + 4'd1;
          if (w_beat_q == aw_len_q) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (w_err_q || w_beat_err) ? SLVERR : OKAY;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bus.BREADY && bvalid_q) begin
          bvalid_d  = 1'b0;
          bresp_d   = OKAY;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read channel next state; r_load fetches the beat presented next cycle.
  always_comb begin
    r_state_d   = r_state_q;
    ar_addr_d   = ar_addr_q;
    ar_len_d    = ar_len_q;
    ar_size_d   = ar_size_q;
    ar_burst_d  = ar_burst_q;
    r_beat_d    = r_beat_q;
    arready_d   = arready_q;
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;
    rid_d       = rid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    r_load      = 1'b0;
    r_load_addr = ar_addr_q;
    r_load_berr = burst_err(ar_size_q, ar_burst_q, ar_len_q);
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (bus.ARVALID && arready_q) begin
          ar_addr_d   = bus.ARADDR;
          ar_len_d    = bus.ARLEN;
          ar_size_d   = bus.ARSIZE;
          ar_burst_d  = bus.ARBURST;
          rid_d       = bus.ARID;
          r_beat_d    = 4'd0;
          arready_d   = 1'b0;
          rvalid_d    = 1'b1;
          rlast_d     = (bus.ARLEN == 4'd0);
          r_load      = 1'b1;
          r_load_addr = bus.ARADDR;
          r_load_berr = burst_err(bus.ARSIZE, bus.ARBURST, bus.ARLEN);
          r_state_d   = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && bus.RREADY) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            rdata_d   = '0;
            rresp_d   = OKAY;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            r_load      = 1'b1;
            r_load_addr = next_addr(ar_addr_q, ar_size_q, ar_burst_q, ar_len_q);
            ar_addr_d   = r_load_addr;
            r_beat_d    = r_beat_q + 4'd1;
            rlast_d     = ((r_beat_q + 4'd1) == ar_len_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    r_load_err = r_load_berr || addr_oor(r_load_addr);
    if (r_load) begin
      rdata_d = r_load_err ? '0 : mem_q[r_load_addr[IDX_W+1:2]];
      rresp_d = r_load_err ? SLVERR : OKAY;
    end
  end

  // RAM with byte-lane write enables; a same-edge read sees the old word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < NBYTE; b++)
        if (bus.WSTRB[b]) mem_q[mem_widx][8*b +: 8] <= bus.WDATA[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q  <= W_IDLE;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_beat_q   <= '0;
      w_err_q    <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= '0;
      r_state_q  <= R_IDLE;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_beat_q   <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      w_state_q  <= w_state_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      w_beat_q   <= w_beat_d;
      w_err_q    <= w_err_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
      r_state_q  <= r_state_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      r_beat_q   <= r_beat_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end
endmodule

// File: tb/tb_axi_modport_slave.sv
// Directed bench for axi_modport_slave: bursts, strobes, stalls, errors, reset.
module tb_axi_modport_slave;
  localparam int TMO = 20;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [31:0] wd  [16];
  logic [31:0] rex [16];

  axi_modport_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_modport_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One write burst from wd[]; bad_last raises WLAST on every beat.
  task automatic axi_write(input string tag, input logic [31:0] addr, input logic [3:0] id,
      input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst,
      input logic [3:0] strb, input logic bad_last, input logic [1:0] exp_resp);
    int t;
    @(negedge clk);
    bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size;
    bus.AWBURST = burst; bus.AWVALID = 1'b1;
    t = 0;
    while (!bus.AWREADY && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) check({tag, "_awready_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    bus.AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.WDATA = wd[i]; bus.WSTRB = strb; bus.WID = id;
      bus.WLAST = bad_last || (i == int'(len)); bus.WVALID = 1'b1;
      t = 0;
      while (!bus.WREADY && t < TMO) begin @(negedge clk); t++; end
      if (t >= TMO) check({tag, "_wready_timeout"}, 32'd0, 32'd1);
      @(negedge clk);
    end
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    check({tag, "_bvalid"}, 32'(bus.BVALID), 32'd1);
    check({tag, "_bid"},    32'(bus.BID),    32'(id));
    check({tag, "_bresp"},  32'(bus.BRESP),  32'(exp_resp));
    bus.BREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0;
    check({tag, "_bvalid_drop"}, 32'(bus.BVALID), 32'd0);
  endtask

  // One read burst checked against rex[]; stall holds RREADY low before beat 0.
  task automatic axi_read(input string tag, input logic [31:0] addr, input logic [3:0] id,
      input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst,
      input logic [1:0] exp_resp, input int stall);
    int t;
    @(negedge clk);
    bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = size;
    bus.ARBURST = burst; bus.ARVALID = 1'b1;
    t = 0;
    while (!bus.ARREADY && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) check({tag, "_arready_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    bus.ARVALID = 1'b0;
    for (int s = 0; s < stall; s++) begin
      check({tag, "_stall_rdata"}, bus.RDATA, rex[0]);
      check({tag, "_stall_rlast"}, 32'(bus.RLAST), 32'(len == 4'd0));
      @(negedge clk);
    end
    for (int i = 0; i <= int'(len); i++) begin
      t = 0;
      while (!bus.RVALID && t < TMO) begin @(negedge clk); t++; end
      if (t >= TMO) check({tag, "_rvalid_timeout"}, 32'd0, 32'd1);
      check({tag, "_rid"},   32'(bus.RID),   32'(id));
      check({tag, "_rdata"}, bus.RDATA,      rex[i]);
      check({tag, "_rresp"}, 32'(bus.RRESP), 32'(exp_resp));
      check({tag, "_rlast"}, 32'(bus.RLAST), 32'(i == int'(len)));
      bus.RREADY = 1'b1;
      @(negedge clk);
      bus.RREADY = 1'b0;
    end
    check({tag, "_rvalid_drop"}, 32'(bus.RVALID),  32'd0);
    check({tag, "_arready"},     32'(bus.ARREADY), 32'd1);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b0;
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
    bus.AWVALID = 1'b0; bus.WID = '0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0;
    bus.WVALID = 1'b0; bus.BREADY = 1'b0; bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0;
    bus.ARSIZE = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    for (int i = 0; i < 16; i++) begin wd[i] = '0; rex[i] = '0; end

    repeat (3) @(negedge clk);
    check("rst_awready", 32'(bus.AWREADY), 32'd0);
    check("rst_arready", 32'(bus.ARREADY), 32'd0);
    check("rst_bvalid",  32'(bus.BVALID),  32'd0);
    check("rst_rvalid",  32'(bus.RVALID),  32'd0);
    rst = 1'b1;
    #1 check("rel_awready_low", 32'(bus.AWREADY), 32'd0);
    @(negedge clk);
    check("rel_awready", 32'(bus.AWREADY), 32'd1);
    check("rel_arready", 32'(bus.ARREADY), 32'd1);

    // Single write then read back
    wd[0] = 32'hDEADBEEF;
    axi_write("single_w", 32'h10, 4'd3, 4'd0, 3'd2, 2'b01, 4'hF, 1'b0, 2'b00);
    rex[0] = 32'hDEADBEEF;
    axi_read("single_r", 32'h10, 4'd5, 4'd0, 3'd2, 2'b01, 2'b00, 0);

    // INCR burst
    for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
    axi_write("incr_w", 32'h20, 4'd1, 4'd3, 3'd2, 2'b01, 4'hF, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) rex[i] = 32'(i + 1);
    axi_read("incr_r", 32'h20, 4'd2, 4'd3, 3'd2, 2'b01, 2'b00, 0);

    // WRAP burst starting mid-window
    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
    axi_write("wrap_w", 32'h38, 4'd7, 4'd3, 3'd2, 2'b10, 4'hF, 1'b0, 2'b00);
    rex[0] = 32'hC; rex[1] = 32'hD; rex[2] = 32'hA; rex[3] = 32'hB;
    axi_read("wrap_r", 32'h30, 4'd8, 4'd3, 3'd2, 2'b01, 2'b00, 0);

    // FIXED burst: both beats land on one word
    wd[0] = 32'h5; wd[1] = 32'h6;
    axi_write("fixed_w", 32'h60, 4'd4, 4'd1, 3'd2, 2'b00, 4'hF, 1'b0, 2'b00);
    rex[0] = 32'h6;
    axi_read("fixed_r", 32'h60, 4'd4, 4'd0, 3'd2, 2'b01, 2'b00, 0);

    // Strobed write over zero word, read with 3-cycle backpressure
    wd[0] = 32'h11223344;
    axi_write("strb_w", 32'h50, 4'd9, 4'd0, 3'd2, 2'b01, 4'b0101, 1'b0, 2'b00);
    rex[0] = 32'h00220044;
    axi_read("strb_r", 32'h50, 4'd9, 4'd0, 3'd2, 2'b01, 2'b00, 3);

    // Out-of-range write must not alias onto word 0
    wd[0] = 32'hCAFEF00D;
    axi_write("oor_w", 32'h400, 4'd2, 4'd0, 3'd2, 2'b01, 4'hF, 1'b0, 2'b10);
    rex[0] = 32'h0;
    axi_read("alias_r", 32'h0, 4'd2, 4'd0, 3'd2, 2'b01, 2'b00, 0);
    axi_read("oor_r", 32'h400, 4'd6, 4'd0, 3'd2, 2'b01, 2'b10, 0);
    axi_read("size3_r", 32'h10, 4'd6, 4'd0, 3'd3, 2'b01, 2'b10, 0);

    // WLAST on the first of two beats
    wd[0] = 32'h1; wd[1] = 32'h2;
    axi_write("wlast_w", 32'h70, 4'd11, 4'd1, 3'd2, 2'b01, 4'hF, 1'b1, 2'b10);

    // Reset during beat 2 of an 8-beat read
    @(negedge clk);
    bus.ARID = 4'd1; bus.ARADDR = 32'h20; bus.ARLEN = 4'd7; bus.ARSIZE = 3'd2;
    bus.ARBURST = 2'b01; bus.ARVALID = 1'b1;
    @(negedge clk);
    bus.ARVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("mid_rdata", bus.RDATA, 32'(i + 1));
      bus.RREADY = 1'b1;
      @(negedge clk);
      bus.RREADY = 1'b0;
    end
    check("mid_beat2", bus.RDATA, 32'd3);
    rst = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(bus.RVALID), 32'd0);
    check("mid_rst_rdata",  bus.RDATA,       32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rel_arready", 32'(bus.ARREADY), 32'd1);
    rex[0] = 32'h0;
    axi_read("cleared_r", 32'h20, 4'd0, 4'd0, 3'd2, 2'b01, 2'b00, 0);
    axi_read("cleared2_r", 32'h10, 4'd0, 4'd0, 3'd2, 2'b01, 2'b00, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
